apb_master_bridge: RTL and testbench

APB initiator that turns a simple valid/ready command stream into APB3 transfers toward the SPI register block (TX_DATA 0x0, RX_DATA 0x4, CFG 0x8, CTRL 0xC, STT 0x10). It drives SETUP and ACCESS phases, waits on pready, and returns read data, error and timeout status on a one-cycle response strobe. It sits between a CPU-side or sequencer command source and the APB slave, replacing hand-driven bus stimulus.

---
 rtl/apb_master_pkg.sv | 15 +
 rtl/apb_master_bridge_timer.sv | 44 ++++
 rtl/apb_master_bridge.sv | 160 ++++++++++++++++
 tb/tb_apb_master_bridge.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_master_pkg.sv
// Shared definitions for the APB master bridge.
//   state_e    : bridge phase (IDLE, SETUP, ACCESS, RESP)
//   ALIGN_MASK : low address bits that must be zero for a word transfer
package apb_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/apb_master_bridge_timer.sv
// Wait-state counter for the ACCESS phase.
//   clk, rst   : clock, asynchronous active-low reset
//   clear_i    : zero the counter (entry into SETUP)
//   enable_i   : one more cycle spent waiting on pready
//   expire_o   : this waiting cycle is the LIMIT-th one; abort on this edge
// LIMIT = 0 disables expiry and freezes the counter.
module apb_wait_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int unsigned CW = (LIMIT == 0) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = (LIMIT == 0) ? '0 : CW'(LIMIT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // The counter reaches LIMIT on the same edge the bridge leaves ACCESS,
  // so it never needs to wrap or saturate.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (LIMIT != 0)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = (LIMIT != 0) && enable_i && (count_q == LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// APB3 initiator: converts a valid/ready command stream into single APB
// transfers and reports each outcome on a one-cycle response strobe.
//   clk, rst                      : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           : command handshake (ready only in IDLE)
//   cmd_write/cmd_addr/cmd_wdata  : command contents
//   rsp_valid                     : one-cycle response strobe
//   rsp_rdata/rsp_slverr/rsp_timeout : response payload, held until next RESP
//   psel/penable/pwrite/paddr/pwdata : APB request side
//   prdata/pready/pslverr         : APB completion side
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_slverr,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  state_e            state_q;
  logic              psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_slverr_q;
  logic              rsp_timeout_q;

  logic              accept;
  logic              misaligned;
  logic              timer_clear;
  logic              timer_en;
  logic              timer_expire;
  logic [DATA_W-1:0] rdata_d;

  assign accept     = (state_q == IDLE) && cmd_valid;
  assign misaligned = (cmd_addr[1:0] & ALIGN_MASK) != 2'b00;

  // Counter restarts on every aligned accept and counts only stalled
  // ACCESS cycles.
  assign timer_clear = accept && !misaligned;
  assign timer_en    = (state_q == ACCESS) && !pready;

  // Writes report zero read data regardless of what the slave drives.
  assign rdata_d = pwrite_q ? '0 : prdata;

  apb_wait_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear_i (timer_clear),
    .enable_i(timer_en),
    .expire_o(timer_expire)
  );

  // Single FSM with all bus and response outputs registered. Address,
  // direction and write data are captured at accept and left untouched
  // afterwards, so they stay stable across ACCESS and hold in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            pwrite_q <= cmd_write;
            paddr_q  <= cmd_addr;
            pwdata_q <= cmd_wdata;
            if (misaligned) begin
              // Rejected locally: straight to a response, bus untouched.
              state_q       <= RESP;
              rsp_valid_q   <= 1'b1;
              rsp_rdata_q   <= '0;
              rsp_slverr_q  <= 1'b1;
              rsp_timeout_q <= 1'b0;
            end else begin
              state_q   <= SETUP;
              psel_q    <= 1'b1;
              penable_q <= 1'b0;
            end
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
        end
        ACCESS: begin
          if (pready) begin
            state_q       <= RESP;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= rdata_d;
            rsp_slverr_q  <= pslverr;
            rsp_timeout_q <= 1'b0;
          end else if (timer_expire) begin
            state_q       <= RESP;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b1;
            rsp_timeout_q <= 1'b1;
          end
        end
        RESP: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_slverr  = rsp_slverr_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Testbench for apb_master_bridge: drives commands, models an APB slave
// with programmable wait states, and checks responses from a queue of
// expected results.
module tb_apb_master_bridge;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TMO    = 16;

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_slverr;
  logic              rsp_timeout;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              tmo;
  } exp_t;

  exp_t sb[$];

  int                slvWaits = 0;
  logic [DATA_W-1:0] slvRdata = '0;
  logic              slvErr   = 1'b0;
  int                waitCnt  = 0;

  apb_master_bridge #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_slverr (rsp_slverr),
    .rsp_timeout(rsp_timeout),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: inserts slvWaits stalled ACCESS cycles before pready.
  assign pready  = psel && penable && (waitCnt >= slvWaits);
  assign prdata  = pready ? slvRdata : 32'hDEAD_BEEF;
  assign pslverr = pready && slvErr;

  always @(posedge clk) begin
    if (psel && penable && !pready) waitCnt <= waitCnt + 1;
    else waitCnt <= 0;
  end

  // penable must never be high while psel is low.
  always @(negedge clk) begin
    if (rst) begin
      total++;
      if (penable && !psel) begin
        bad++;
        $display("[TB] FAIL penable_without_psel: penable=%b psel=%b required penable=0", penable, psel);
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Issues one command, then watches the bus until rsp_valid (bounded).
  task automatic runCmd(input bit wr, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, input int waits,
                        input logic [DATA_W-1:0] rdata, input bit err,
                        output int lat, output int pselCnt, output bit seen,
                        output bit busOk, output logic [DATA_W-1:0] oRdata,
                        output logic oErr, output logic oTmo,
                        output logic validAfter, output logic readyAfter);
    slvWaits = waits;
    slvRdata = rdata;
    slvErr   = err;
    lat = 0; pselCnt = 0; seen = 1'b0; busOk = 1'b1;
    oRdata = '0; oErr = 1'b0; oTmo = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    if (!cmd_ready) busOk = 1'b0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_write = ~wr;
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (psel) begin
        pselCnt++;
        if (paddr !== addr || pwdata !== wdata || pwrite !== wr) busOk = 1'b0;
        if (penable !== (pselCnt > 1)) busOk = 1'b0;
      end
      if (rsp_valid) begin
        seen   = 1'b1;
        oRdata = rsp_rdata;
        oErr   = rsp_slverr;
        oTmo   = rsp_timeout;
      end
    end
    @(negedge clk);
    validAfter = rsp_valid;
    readyAfter = cmd_ready;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    #12;
    total++;
    if ({psel, penable, pwrite, rsp_valid, rsp_slverr, rsp_timeout} !== 6'b0) begin
      bad++;
      $display("[TB] FAIL reset_ctrl: got %b required 000000",
               {psel, penable, pwrite, rsp_valid, rsp_slverr, rsp_timeout});
    end
    total++;
    if (paddr !== '0 || pwdata !== '0 || rsp_rdata !== '0) begin
      bad++;
      $display("[TB] FAIL reset_data: paddr=%h pwdata=%h rdata=%h required all 0", paddr, pwdata, rsp_rdata);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_ready: cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  // Runs one transfer with scoreboarded response and latency expectations.
  task automatic xfer(input string name, input bit wr, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] wdata, input int waits,
                      input logic [DATA_W-1:0] rdata, input bit err,
                      input exp_t e, input int expLat, input int expPsel);
    int lat, pselCnt;
    bit seen, busOk;
    logic [DATA_W-1:0] oRdata;
    logic oErr, oTmo, validAfter, readyAfter;
    exp_t got;
    exp_t want;
    sb.push_back(e);
    runCmd(wr, addr, wdata, waits, rdata, err, lat, pselCnt, seen, busOk,
           oRdata, oErr, oTmo, validAfter, readyAfter);
    total++;
    if (!seen) begin
      bad++;
      $display("[TB] FAIL %s_rsp: no rsp_valid within bound, required one", name);
      void'(sb.pop_front());
      return;
    end
    want = sb.pop_front();
    got.rdata = oRdata; got.err = oErr; got.tmo = oTmo;
    if (got.rdata !== want.rdata || got.err !== want.err || got.tmo !== want.tmo) begin
      bad++;
      $display("[TB] FAIL %s_rsp: rdata=%h err=%b tmo=%b required rdata=%h err=%b tmo=%b",
               name, got.rdata, got.err, got.tmo, want.rdata, want.err, want.tmo);
    end
    total++;
    if (lat !== expLat) begin
      bad++;
      $display("[TB] FAIL %s_latency: got %0d required %0d", name, lat, expLat);
    end
    total++;
    if (pselCnt !== expPsel) begin
      bad++;
      $display("[TB] FAIL %s_psel_cycles: got %0d required %0d", name, pselCnt, expPsel);
    end
    total++;
    if (busOk !== 1'b1) begin
      bad++;
      $display("[TB] FAIL %s_bus: bus signals unstable or wrong phase, got %b required 1", name, busOk);
    end
    total++;
    if (validAfter !== 1'b0 || readyAfter !== 1'b1) begin
      bad++;
      $display("[TB] FAIL %s_after: rsp_valid=%b cmd_ready=%b required 0 and 1", name, validAfter, readyAfter);
    end
  endtask

  task automatic test_write_basic();
    exp_t e;
    e.rdata = '0; e.err = 1'b0; e.tmo = 1'b0;
    xfer("write_cfg", 1'b1, 32'h8, 32'h0000_01FF, 0, 32'h1111_2222, 1'b0, e, 3, 2);
  endtask

  task automatic test_read_wait();
    exp_t e;
    e.rdata = 32'hAABB_CCDD; e.err = 1'b0; e.tmo = 1'b0;
    xfer("read_wait", 1'b0, 32'h4, 32'h0, 3, 32'hAABB_CCDD, 1'b0, e, 6, 5);
  endtask

  task automatic test_slverr();
    exp_t e;
    e.rdata = '0; e.err = 1'b1; e.tmo = 1'b0;
    xfer("slverr", 1'b1, 32'h14, 32'h0000_5A5A, 0, 32'h7777_7777, 1'b1, e, 3, 2);
    e.rdata = 32'h1234_5678; e.err = 1'b0; e.tmo = 1'b0;
    xfer("after_err", 1'b0, 32'h8, 32'h0, 0, 32'h1234_5678, 1'b0, e, 3, 2);
  endtask

  task automatic test_misaligned();
    exp_t e;
    e.rdata = '0; e.err = 1'b1; e.tmo = 1'b0;
    xfer("misaligned", 1'b0, 32'hFF, 32'h0, 0, 32'hCAFE_F00D, 1'b0, e, 1, 0);
  endtask

  task automatic test_timeout();
    exp_t e;
    e.rdata = '0; e.err = 1'b1; e.tmo = 1'b1;
    xfer("timeout", 1'b0, 32'h10, 32'h0, 1000, 32'h5555_AAAA, 1'b0, e, TMO + 2, TMO + 1);
  endtask

  task automatic test_random();
    exp_t e;
    bit wr;
    int waits;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    for (int i = 0; i < 4; i++) begin
      wr    = 1'($urandom_range(0, 1));
      waits = $urandom_range(0, 3);
      addr  = {27'h0, 3'($urandom_range(0, 4)), 2'b00};
      data  = $urandom;
      e.rdata = wr ? '0 : data;
      e.err   = 1'b0;
      e.tmo   = 1'b0;
      xfer("random", wr, addr, data, waits, data, 1'b0, e, 3 + waits, 2 + waits);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit inAccess;
    slvWaits = 1000;
    slvErr   = 1'b0;
    inAccess = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'hC; cmd_wdata = 32'h0000_00C3;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (penable) begin
        inAccess = 1'b1;
        break;
      end
    end
    total++;
    if (!inAccess) begin
      bad++;
      $display("[TB] FAIL mid_reach_access: penable=%b required 1", penable);
    end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (psel !== 1'b0 || penable !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mid_async_drop: psel=%b penable=%b required 0 0", psel, penable);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b0 || psel !== 1'b0) begin
        bad++;
        $display("[TB] FAIL mid_no_rsp: rsp_valid=%b psel=%b required 0 0", rsp_valid, psel);
      end
    end
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mid_ready: cmd_ready=%b required 1", cmd_ready);
    end
    e.rdata = '0; e.err = 1'b0; e.tmo = 1'b0;
    xfer("post_reset", 1'b1, 32'h0, 32'h0000_00A5, 0, 32'h9999_9999, 1'b0, e, 3, 2);
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_wait();
    test_slverr();
    test_misaligned();
    test_timeout();
    test_random();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
